// File: rtl/goldilocks_modred_if.sv
// Handshake-free product/residue bus between the Karatsuba multiplier and the
// Goldilocks reduction stage.
interface goldilocks_modred_if #(
  parameter int N  = 64,
  parameter int TW = 8
);
  logic              in_valid;
  logic [2*N-1:0]    in_data;
  logic [TW-1:0]     in_tag;
  logic              out_valid;
  logic [N-1:0]      out_data;
  logic [TW-1:0]     out_tag;

  modport master (
    output in_valid, in_data, in_tag,
    input  out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_tag,
    output out_valid, out_data, out_tag
  );
endinterface

// File: rtl/goldilocks_modred.sv
// 3-stage shift/add reduction of a 128-bit product modulo q = 2^64 - 2^32 + 1.
// Define GOLDILOCKS_MODRED_OUT_REG_EN to add a 4th output register stage.
module goldilocks_modred #(
  parameter int N  = 64,
  parameter int TW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  goldilocks_modred_if.slave   bus
);
`ifdef GOLDILOCKS_MODRED_OUT_REG_EN
  localparam int STAGES = 4;
`else
  localparam int STAGES = 3;
`endif
  localparam int H = N / 2;
  localparam logic [N-1:0] Q   = {{H{1'b1}}, {(H-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] EPS = {{H{1'b0}}, {H{1'b1}}};

  logic [STAGES:1]         vld_pipe_q;
  logic [STAGES:1][TW-1:0] tag_pipe_q;

  // Valid and tag travel together; tags only advance with a valid operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], bus.in_valid};
      if (bus.in_valid) tag_pipe_q[1] <= bus.in_tag;
      for (int i = 2; i <= STAGES; i++)
        if (vld_pipe_q[i-1]) tag_pipe_q[i] <= tag_pipe_q[i-1];
    end
  end

  // Stage 1: a = x_lo - x3 (+q on borrow), b = x2 * (2^32 - 1)
  logic [N-1:0] x_lo;
  logic [H-1:0] x2, x3;
  logic [N:0]   diff;
  logic [N-1:0] a_d, b_d, a_q, b_q;

  assign x_lo = bus.in_data[N-1:0];
  assign x2   = bus.in_data[N+H-1:N];
  assign x3   = bus.in_data[2*N-1:N+H];
  assign diff = {1'b0, x_lo} - {{(H+1){1'b0}}, x3};
  assign a_d  = diff[N] ? diff[N-1:0] - EPS : diff[N-1:0];
  assign b_d  = {x2, {H{1'b0}}} - {{H{1'b0}}, x2};

  // Stage 2: fold the carry of a + b back in as 2^64 == 2^32 - 1
  logic [N:0]   sum;
  logic [N-1:0] s_d, s_q;

  assign sum = {1'b0, a_q} + {1'b0, b_q};
  assign s_d = sum[N] ? sum[N-1:0] + EPS : sum[N-1:0];

  // Stage 3: s < 2q, so one conditional subtract yields the canonical residue
  logic [N-1:0] r_d, r_q;

  assign r_d = (s_q >= Q) ? s_q - Q : s_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      r_q <= '0;
    end else begin
      if (bus.in_valid) begin
        a_q <= a_d;
        b_q <= b_d;
      end
      if (vld_pipe_q[1]) s_q <= s_d;
      if (vld_pipe_q[2]) r_q <= r_d;
    end
  end

`ifdef GOLDILOCKS_MODRED_OUT_REG_EN
  logic [N-1:0] o_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                o_q <= '0;
    else if (vld_pipe_q[3]) o_q <= r_q;
  end

  assign bus.out_data = o_q;
`else
  assign bus.out_data = r_q;
`endif

  assign bus.out_valid = vld_pipe_q[STAGES];
  assign bus.out_tag   = tag_pipe_q[STAGES];
endmodule
